// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory accesses over a req/ready handshake, aligns and extends
// load data, and feeds the registered writeback latch.
module memory_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            MEM_V,
    input  logic [3:0]      MEM_Cst,
    input  logic [XLEN-1:0] MEM_ALU_RES,
    input  logic [XLEN-1:0] MEM_Store_Data,
    input  logic            MEM_PC_MUX,
    input  logic [XLEN-1:0] MEM_NPC,
    input  logic [31:0]     MEM_IR,
    input  logic [XLEN-1:0] MEM_Target_Address,
    input  logic            MEM_FLUSH,
    output logic            MEM_STALL,
    output logic            MEM_MISALIGN,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [XLEN-1:0] DMEM_WDATA,
    output logic [7:0]      DMEM_WSTRB,
    input  logic [XLEN-1:0] DMEM_RDATA,
    input  logic            DMEM_READY,
    output logic            WB_V,
    output logic [3:0]      WB_Cst,
    output logic [XLEN-1:0] WB_RES,
    output logic            WB_PC_MUX,
    output logic [XLEN-1:0] WB_NPC,
    output logic [31:0]     WB_IR,
    output logic [XLEN-1:0] WB_Target_Address
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e          state_q;
    logic [XLEN-1:0] hold_addr_q, hold_wdata_q;
    logic [7:0]      hold_strb_q;
    logic            hold_we_q;

    logic [2:0]      funct3, off, align_mask;
    logic [7:0]      lane_mask, req_strb;
    logic [XLEN-1:0] req_addr, req_wdata, rd_shift, load_ext;
    logic            memop, misaligned, idle_req, req_raw, sext, wb_bubble;

    assign funct3    = MEM_IR[14:12];
    assign off       = MEM_ALU_RES[2:0];
    assign memop     = MEM_V & (MEM_Cst[1] | MEM_Cst[2]);
    assign sext      = ~funct3[2];
    assign req_addr  = {MEM_ALU_RES[XLEN-1:3], 3'b000};
    assign req_strb  = lane_mask << off;
    assign req_wdata = MEM_Store_Data << {off, 3'b000};
    assign rd_shift  = DMEM_RDATA >> {off, 3'b000};

    always_comb begin
        align_mask = 3'b000;
        lane_mask  = 8'h01;
        load_ext   = rd_shift;
        unique case (funct3[1:0])
            2'd0: begin
                align_mask = 3'b000;
                lane_mask  = 8'h01;
                load_ext   = {{56{sext & rd_shift[7]}}, rd_shift[7:0]};
            end
            2'd1: begin
                align_mask = 3'b001;
                lane_mask  = 8'h03;
                load_ext   = {{48{sext & rd_shift[15]}}, rd_shift[15:0]};
            end
            2'd2: begin
                align_mask = 3'b011;
                lane_mask  = 8'h0F;
                load_ext   = {{32{sext & rd_shift[31]}}, rd_shift[31:0]};
            end
            default: begin
                align_mask = 3'b111;
                lane_mask  = 8'hFF;
                load_ext   = rd_shift;
            end
        endcase
    end

    assign misaligned = memop & ((off & align_mask) != 3'b000);
    assign idle_req   = memop & ~misaligned & ~MEM_FLUSH;

    // Once an access is outstanding, the memory side is driven from the captured copy so the
    // request stays stable even after a flush lets upstream move on.
    always_comb begin
        req_raw     = 1'b1;
        DMEM_WE     = hold_we_q;
        DMEM_ADDR   = hold_addr_q;
        DMEM_WDATA  = hold_wdata_q;
        DMEM_WSTRB  = hold_strb_q;
        if (state_q == StIdle) begin
            req_raw    = idle_req;
            DMEM_WE    = MEM_Cst[2];
            DMEM_ADDR  = req_addr;
            DMEM_WDATA = req_wdata;
            DMEM_WSTRB = req_strb;
        end
    end

    // Reset also silences the memory side while it is held.
    assign DMEM_REQ     = RESET_N & req_raw;
    assign MEM_STALL    = DMEM_REQ & ~DMEM_READY;
    assign MEM_MISALIGN = RESET_N & (state_q == StIdle) & misaligned & ~MEM_FLUSH;
    assign wb_bubble    = MEM_STALL | MEM_FLUSH | (state_q == StDrain);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_strb_q  <= '0;
            hold_we_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (idle_req && !DMEM_READY) begin
                        state_q      <= StBusy;
                        hold_addr_q  <= req_addr;
                        hold_wdata_q <= req_wdata;
                        hold_strb_q  <= req_strb;
                        hold_we_q    <= MEM_Cst[2];
                    end
                end
                StBusy: begin
                    if (DMEM_READY) begin
                        state_q <= StIdle;
                    end else if (MEM_FLUSH) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (DMEM_READY) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WB_V              <= 1'b0;
            WB_Cst            <= '0;
            WB_RES            <= '0;
            WB_PC_MUX         <= 1'b0;
            WB_NPC            <= '0;
            WB_IR             <= '0;
            WB_Target_Address <= '0;
        end else if (wb_bubble) begin
            WB_V <= 1'b0;
        end else begin
            WB_V              <= MEM_V;
            // A suppressed misaligned access still retires, but must not write a register.
            WB_Cst            <= {MEM_Cst[3:1], MEM_Cst[0] & ~misaligned};
            WB_RES            <= (MEM_Cst[1] && !misaligned) ? load_ext : MEM_ALU_RES;
            WB_PC_MUX         <= MEM_PC_MUX;
            WB_NPC            <= MEM_NPC;
            WB_IR             <= MEM_IR;
            WB_Target_Address <= MEM_Target_Address;
        end
    end

endmodule
